scr_stack_ctrl: RTL and testbench

// Sequencer sitting directly upstream of the scratch RAM. Owns the stack pointer.

---
 rtl/scr_pkg.sv | 27 ++
 rtl/scr_stack_ctrl_if.sv | 35 +++
 rtl/scr_sp_counter.sv | 44 ++++
 rtl/scr_stack_ctrl.sv | 125 ++++++++++++
 tb/tb_scr_stack_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/scr_pkg.sv
// Shared types and defaults for the scratch-RAM stack sequencer.
package scr_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_LD   = 3'd3,
    OP_ST   = 3'd4,
    OP_WSP  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Codes 6 and 7 are unassigned and are dropped like NOP.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

endpackage

// File: rtl/scr_stack_ctrl_if.sv
// Request/response handshake plus scratch RAM bus of the stack sequencer.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable while valid=1 and ready=0.
interface scr_stack_ctrl_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] sp;
  logic              err_ovf;
  logic              err_unf;
  logic [ADDR_W-1:0] scr_addr;
  logic              scr_we;
  logic [DATA_W-1:0] scr_din;
  logic [DATA_W-1:0] scr_dout;

  modport master (
    output req_valid, req_op, req_addr, req_data, rd_ready, scr_dout,
    input  req_ready, rd_valid, rd_data, sp, err_ovf, err_unf,
           scr_addr, scr_we, scr_din
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rd_ready, scr_dout,
    output req_ready, rd_valid, rd_data, sp, err_ovf, err_unf,
           scr_addr, scr_we, scr_din
  );
endinterface

// File: rtl/scr_sp_counter.sv
// Stack pointer and live-entry depth. The stack grows downward; depth saturates
// at the bounds instead of wrapping, while SP wraps modulo the RAM depth.
module scr_sp_counter #(
  parameter  int ADDR_W    = 8,
  parameter  int MAX_DEPTH = 256,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [ADDR_W-1:0]  i_load_val,
  input  logic               i_push,
  input  logic               i_pop,
  output logic [ADDR_W-1:0]  o_sp,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_full,
  output logic               o_empty
);

  logic [ADDR_W-1:0]  r_sp;
  logic [DEPTH_W-1:0] r_depth;

  assign o_sp    = r_sp;
  assign o_depth = r_depth;
  assign o_full  = (r_depth == DEPTH_W'(MAX_DEPTH));
  assign o_empty = (r_depth == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= '0;
      r_depth <= '0;
    end else if (i_load) begin
      r_sp    <= i_load_val;
      r_depth <= '0;
    end else if (i_push && !o_full) begin
      r_sp    <= r_sp - ADDR_W'(1);
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (i_pop && !o_empty) begin
      r_sp    <= r_sp + ADDR_W'(1);
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/scr_stack_ctrl.sv
// Scratch RAM sequencer: turns single requests into RAM accesses, owns the stack
// pointer, and returns POP/LD results through a registered valid/ready port.
module scr_stack_ctrl
  import scr_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int ADDR_W    = ADDR_W_DEF,
  parameter  int MAX_DEPTH = 256,
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  scr_stack_ctrl_if.slave    bus,
  output state_e             o_state,
  output logic [DEPTH_W-1:0] o_depth
);

  state_e            r_state, w_next;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_ovf, r_unf;

  logic [ADDR_W-1:0] w_sp;
  logic              w_full, w_empty;
  logic              w_exec, w_load, w_push, w_pop;
  logic              w_req_ready, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;

  assign w_exec = (r_state == ST_EXEC);
  assign w_load = w_exec && (r_op == OP_WSP);
  assign w_push = w_exec && (r_op == OP_PUSH);
  assign w_pop  = w_exec && (r_op == OP_POP);

  scr_sp_counter #(.ADDR_W(ADDR_W), .MAX_DEPTH(MAX_DEPTH)) u_sp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (r_addr),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .o_sp       (w_sp),
    .o_depth    (o_depth),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // RAM strobes exist only in EXEC, so a reset drops SCR_WE without a clock.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_we        = 1'b0;
    w_addr      = w_sp;
    w_din       = '0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid && is_legal_op(bus.req_op)) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_next = ((r_op == OP_POP) || (r_op == OP_LD)) ? ST_RESP : ST_IDLE;
        case (r_op)
          OP_PUSH: begin
            if (!w_full) begin
              w_addr = w_sp - ADDR_W'(1);
              w_we   = 1'b1;
              w_din  = r_data;
            end
          end
          OP_LD: w_addr = r_addr;
          OP_ST: begin
            w_addr = r_addr;
            w_we   = 1'b1;
            w_din  = r_data;
          end
          default: ;
        endcase
      end
      ST_RESP: begin
        if (bus.rd_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_NOP;
      r_addr    <= '0;
      r_data    <= '0;
      r_rd_data <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.req_valid) begin
        r_op   <= op_e'(bus.req_op);
        r_addr <= bus.req_addr;
        r_data <= bus.req_data;
      end
      r_ovf <= w_push && w_full;
      r_unf <= w_pop && w_empty;
      if (w_pop) r_rd_data <= w_empty ? '0 : bus.scr_dout;
      else if (w_exec && (r_op == OP_LD)) r_rd_data <= bus.scr_dout;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rd_valid  = (r_state == ST_RESP);
  assign bus.rd_data   = r_rd_data;
  assign bus.sp        = w_sp;
  assign bus.err_ovf   = r_ovf;
  assign bus.err_unf   = r_unf;
  assign bus.scr_addr  = w_addr;
  assign bus.scr_we    = w_we;
  assign bus.scr_din   = w_din;
  assign o_state       = r_state;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Bench for scr_stack_ctrl: directed cases plus random traffic against a
// behavioural stack/memory model.
module tb_scr_stack_ctrl;
  import scr_pkg::*;

  localparam int DW = 10;
  localparam int AW = 8;
  localparam int MD = 256;

  logic clk = 1'b0;
  logic rst;
  logic ram_clear;
  always #5 clk = ~clk;

  scr_stack_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  state_e     dbg_state;
  logic [8:0] dbg_depth;

  scr_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_DEPTH(MD)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state),
    .o_depth (dbg_depth)
  );

  // Scratch RAM with combinational read
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (bus.scr_we) begin
      ram[bus.scr_addr] <= bus.scr_din;
    end
  end
  assign bus.scr_dout = ram[bus.scr_addr];

  // Reference model
  int            m_sp;
  int            m_depth;
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input int hold);
    logic          exp_we, exp_ovf, exp_unf, resp, chk_addr;
    int            exp_addr;
    logic [DW-1:0] exp_din;
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_addr", 32'(bus.scr_addr), 32'(m_sp));
    check("idle_din", 32'(bus.scr_din), 32'd0);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = data;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom_range(0, 7));
    bus.req_addr  = 8'($urandom_range(0, 255));
    if (!((op >= 3'd1) && (op <= 3'd5))) begin
      check("nop_state", 32'(dbg_state), 32'(ST_IDLE));
      check("nop_we", 32'(bus.scr_we), 32'd0);
      check("nop_sp", 32'(bus.sp), 32'(m_sp));
      return;
    end
    exp_we = 0; exp_din = '0; exp_addr = m_sp; exp_ovf = 0; exp_unf = 0;
    resp = 0; chk_addr = 0;
    case (op)
      3'd1: begin
        if (m_depth == MD) exp_ovf = 1;
        else begin
          m_sp = (m_sp + 255) % 256;
          exp_addr = m_sp; exp_we = 1; exp_din = data; chk_addr = 1;
          m_mem[m_sp] = data;
          m_depth++;
        end
      end
      3'd2: begin
        resp = 1;
        if (m_depth == 0) begin
          exp_unf = 1;
          exp_q.push_back('0);
        end else begin
          exp_addr = m_sp; chk_addr = 1;
          exp_q.push_back(m_mem[m_sp]);
          m_sp = (m_sp + 1) % 256;
          m_depth--;
        end
      end
      3'd3: begin
        resp = 1; exp_addr = int'(addr); chk_addr = 1;
        exp_q.push_back(m_mem[addr]);
      end
      3'd4: begin
        exp_addr = int'(addr); exp_we = 1; exp_din = data; chk_addr = 1;
        m_mem[addr] = data;
      end
      default: begin
        m_sp = int'(addr);
        m_depth = 0;
      end
    endcase
    check("exec_state", 32'(dbg_state), 32'(ST_EXEC));
    check("exec_ready", 32'(bus.req_ready), 32'd0);
    check("exec_we", 32'(bus.scr_we), 32'(exp_we));
    if (chk_addr) check("exec_addr", 32'(bus.scr_addr), 32'(exp_addr));
    if (exp_we) check("exec_din", 32'(bus.scr_din), 32'(exp_din));
    @(negedge clk);
    check("err_ovf", 32'(bus.err_ovf), 32'(exp_ovf));
    check("err_unf", 32'(bus.err_unf), 32'(exp_unf));
    check("sp", 32'(bus.sp), 32'(m_sp));
    check("depth", 32'(dbg_depth), 32'(m_depth));
    check("post_we", 32'(bus.scr_we), 32'd0);
    if (resp) begin
      for (int h = 0; h < hold; h++) begin
        check("resp_valid", 32'(bus.rd_valid), 32'd1);
        check("resp_ready", 32'(bus.req_ready), 32'd0);
        check("resp_hold", 32'(bus.rd_data), 32'(exp_q[0]));
        @(negedge clk);
      end
      bus.rd_ready = 1'b1;
      check("resp_valid", 32'(bus.rd_valid), 32'd1);
      check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      @(negedge clk);
      bus.rd_ready = 1'b0;
      check("resp_done", 32'(bus.rd_valid), 32'd0);
      check("err_clear", 32'({bus.err_ovf, bus.err_unf}), 32'd0);
    end else begin
      check("back_idle", 32'(dbg_state), 32'(ST_IDLE));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ram_clear = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_sp = 0; m_depth = 0;
    repeat (2) @(negedge clk);

    // Outputs while reset is held
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_sp", 32'(bus.sp), 32'd0);
    check("rst_depth", 32'(dbg_depth), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_we", 32'(bus.scr_we), 32'd0);
    check("rst_errs", 32'({bus.err_ovf, bus.err_unf}), 32'd0);
    check("rst_addr", 32'(bus.scr_addr), 32'd0);
    ram_clear = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // PUSH 0x2A5 from SP=0 wraps to 0xFF, then POP returns it
    do_req(3'd1, 8'h00, 10'h2A5, 0);
    check("t2_sp_ff", 32'(bus.sp), 32'h0FF);
    check("t2_ram_ff", 32'(ram[255]), 32'h2A5);
    do_req(3'd2, 8'h00, 10'h000, 1);
    check("t2_sp_00", 32'(bus.sp), 32'h000);

    // POP on empty stack
    do_req(3'd2, 8'h00, 10'h000, 0);
    check("t3_sp", 32'(bus.sp), 32'h000);

    // Fill to MAX_DEPTH, then one more push overflows
    for (int i = 0; i < MD; i++) do_req(3'd1, 8'h00, 10'($urandom_range(0, 1023)), 0);
    check("t4_full_depth", 32'(dbg_depth), 32'd256);
    do_req(3'd1, 8'h00, 10'h3FF, 0);
    check("t4_sp_kept", 32'(bus.sp), 32'h000);
    for (int i = 0; i < 4; i++) do_req(3'd2, 8'h00, 10'h000, int'($urandom_range(0, 2)));

    // ST then LD with a stalled consumer
    do_req(3'd4, 8'h10, 10'h155, 0);
    do_req(3'd3, 8'h10, 10'h000, 3);

    // Reset during EXEC of a PUSH
    bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_data = 10'h0AA;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t6_we_before", 32'(bus.scr_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_we_async", 32'(bus.scr_we), 32'd0);
    check("t6_ready_async", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    m_sp = 0; m_depth = 0;
    exp_q.delete();
    @(negedge clk);
    check("t6_sp", 32'(bus.sp), 32'd0);
    check("t6_depth", 32'(dbg_depth), 32'd0);
    check("t6_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [2:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 35)      op = 3'd1;
      else if (r < 65) op = 3'd2;
      else if (r < 77) op = 3'd3;
      else if (r < 87) op = 3'd4;
      else if (r < 92) op = 3'd5;
      else if (r < 96) op = 3'd0;
      else             op = 3'($urandom_range(6, 7));
      do_req(op, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
